// File: rtl/ajuste_pkg.sv
// Shared types and default timing for the switching-adjust button front-end.
// States, target/direction encodings, step-pulse mask helper.
package ajuste_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 20_000_000;
  localparam int unsigned DEF_IDX_MAX         = 15;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    HOLD,
    REPEAT,
    WAIT_REL
  } state_t;

  typedef enum logic {
    TGT_FREC = 1'b0,
    TGT_DUTY = 1'b1
  } tgt_sel_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  typedef struct packed {
    dir_t     dir;
    tgt_sel_t sel;
  } tgt_t;

  // Bit order: {dec_duty, inc_duty, dec_frec, inc_frec}
  function automatic logic [3:0] step_mask(tgt_t t);
    logic [1:0] sh;
    sh = {t.sel == TGT_DUTY, t.dir == DIR_DOWN};
    return 4'b0001 << sh;
  endfunction

endpackage

// File: rtl/control_ajuste_conmutacion_sincronizador_antirrebote.sv
// 2-flop synchronizer plus debounce: level follows raw after DEBOUNCE_CYCLES
// equal samples. Ports: clk, rst_n (async low), raw in, level out.
module sincronizador_antirrebote #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/control_ajuste_conmutacion.sv
// Up/down button controller: debounce, route to freq/duty, saturating steps
// with auto-repeat. Ports: clk/reset, buttons, target select, indices, pulses.
module control_ajuste_conmutacion
  import ajuste_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned IDX_MAX         = DEF_IDX_MAX
) (
  input  logic       CLK_100MHz,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       funct_select,
  input  logic [3:0] frec_idx,
  input  logic [3:0] duty_idx,
  output logic       inc_frec,
  output logic       dec_frec,
  output logic       inc_duty,
  output logic       dec_duty,
  output logic       at_limit
);

  localparam int unsigned RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CW = $clog2(RMAX + 1);

  logic          up;
  logic          down;
  state_t        state;
  state_t        state_n;
  tgt_t          tgt;
  tgt_t          tgt_n;
  tgt_t          fire_tgt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          fire;
  logic          held;
  logic          other;
  logic          sat;
  logic [3:0]    fire_idx;
  logic [3:0]    lat_idx;
  logic [3:0]    pulse;
  logic [3:0]    pulse_n;

  sincronizador_antirrebote #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_up (
    .clk  (CLK_100MHz),
    .rst_n(reset),
    .raw  (btn_up),
    .level(up)
  );

  sincronizador_antirrebote #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_down (
    .clk  (CLK_100MHz),
    .rst_n(reset),
    .raw  (btn_down),
    .level(down)
  );

  assign held  = (tgt.dir == DIR_UP) ? up : down;
  assign other = (tgt.dir == DIR_UP) ? down : up;

  // cnt counts cycles since the last step decision
  always_comb begin
    state_n  = state;
    tgt_n    = tgt;
    cnt_n    = cnt + 1'b1;
    fire     = 1'b0;
    fire_tgt = tgt;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (up && down) begin
          state_n = WAIT_REL;
        end else if (up ^ down) begin
          tgt_n.dir = up ? DIR_UP : DIR_DOWN;
          tgt_n.sel = funct_select ? TGT_DUTY : TGT_FREC;
          fire_tgt  = tgt_n;
          fire      = 1'b1;
          state_n   = PRESS;
        end
      end
      PRESS: state_n = HOLD;
      HOLD: begin
        if (!held || other) begin
          state_n = WAIT_REL;
        end else if (cnt == CW'(REPEAT_DELAY - 1)) begin
          fire    = 1'b1;
          cnt_n   = '0;
          state_n = REPEAT;
        end
      end
      REPEAT: begin
        if (!held || other) begin
          state_n = WAIT_REL;
        end else if (cnt == CW'(REPEAT_PERIOD - 1)) begin
          fire  = 1'b1;
          cnt_n = '0;
        end
      end
      WAIT_REL: begin
        cnt_n = '0;
        if (!up && !down) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Saturation only masks the pulse; the schedule keeps running
  always_comb begin
    fire_idx = (fire_tgt.sel == TGT_DUTY) ? duty_idx : frec_idx;
    sat      = (fire_tgt.dir == DIR_UP) ? (fire_idx == 4'(IDX_MAX))
                                        : (fire_idx == 4'd0);
    pulse_n  = '0;
    if (fire && !sat) pulse_n = step_mask(fire_tgt);
  end

  always_ff @(posedge CLK_100MHz or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tgt   <= '0;
      cnt   <= '0;
      pulse <= '0;
    end else begin
      state <= state_n;
      tgt   <= tgt_n;
      cnt   <= cnt_n;
      pulse <= pulse_n;
    end
  end

  assign {dec_duty, inc_duty, dec_frec, inc_frec} = pulse;

  assign lat_idx  = (tgt.sel == TGT_DUTY) ? duty_idx : frec_idx;
  assign at_limit = (state != IDLE) &&
                    ((tgt.dir == DIR_UP) ? (up && lat_idx == 4'(IDX_MAX))
                                         : (down && lat_idx == 4'd0));

endmodule

// File: tb/tb_control_ajuste_conmutacion.sv
// Scoreboard bench for control_ajuste_conmutacion with a behavioural
// reference model and a closed-loop 4-bit counter environment.
module tb_control_ajuste_conmutacion;

  localparam int D    = 4;
  localparam int RD   = 20;
  localparam int RP   = 8;
  localparam int IMAX = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       fs = 1'b0;
  logic [3:0] frec_idx = 4'd0;
  logic [3:0] duty_idx = 4'd0;
  logic       inc_frec, dec_frec, inc_duty, dec_duty, at_limit;

  int n_checks = 0;
  int n_pass = 0;
  int pc = 0;

  always #5 clk = ~clk;

  control_ajuste_conmutacion #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .IDX_MAX(IMAX)
  ) dut (
    .CLK_100MHz  (clk),
    .reset       (rst_n),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .funct_select(fs),
    .frec_idx    (frec_idx),
    .duty_idx    (duty_idx),
    .inc_frec    (inc_frec),
    .dec_frec    (dec_frec),
    .inc_duty    (inc_duty),
    .dec_duty    (dec_duty),
    .at_limit    (at_limit)
  );

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t",
                  name, act, exp, $time);
  endfunction

  // Environment: up/down counters driven by the pulses, with preload
  logic       ld = 1'b0;
  logic [3:0] ld_f = 4'd0;
  logic [3:0] ld_d = 4'd0;

  always @(posedge clk) begin
    if (ld) begin
      frec_idx <= ld_f;
      duty_idx <= ld_d;
    end else begin
      if (inc_frec) frec_idx <= frec_idx + 4'd1;
      if (dec_frec) frec_idx <= frec_idx - 4'd1;
      if (inc_duty) duty_idx <= duty_idx + 4'd1;
      if (dec_duty) duty_idx <= duty_idx - 4'd1;
    end
  end

  // Reference model. kind: 0 inc_frec, 1 dec_frec, 2 inc_duty, 3 dec_duty
  typedef struct {
    int cyc;
    int kind;
  } ev_t;
  typedef enum int {M_IDLE, M_ACT, M_WAIT} mmode_t;

  ev_t    q[$];
  int     cyc = 0;
  bit     su1, su2, mdu, sd1, sd2, mdd;
  int     ru, rdn;
  mmode_t mm = M_IDLE;
  bit     m_up, m_duty;
  int     m_t;
  int     ef = 0;
  int     ed = 0;

  function automatic void adj(int kind, int s);
    case (kind)
      0: ef = ef + s;
      1: ef = ef - s;
      2: ed = ed + s;
      default: ed = ed - s;
    endcase
  endfunction

  function automatic void try_fire();
    int  idx;
    ev_t e;
    idx = m_duty ? int'(duty_idx) : int'(frec_idx);
    if (m_up ? (idx != IMAX) : (idx != 0)) begin
      e.cyc  = cyc;
      e.kind = (m_duty ? 2 : 0) + (m_up ? 0 : 1);
      q.push_back(e);
      adj(e.kind, 1);
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // a pulse killed by reset never reaches the counter
      while (q.size() > 0) adj(q.pop_back().kind, -1);
      su1 = 0; su2 = 0; mdu = 0; ru = 0;
      sd1 = 0; sd2 = 0; mdd = 0; rdn = 0;
      mm = M_IDLE; m_t = 0;
    end else begin
      cyc++;
      if (ld) begin
        ef = int'(ld_f);
        ed = int'(ld_d);
      end
      case (mm)
        M_IDLE: begin
          if (mdu && mdd) mm = M_WAIT;
          else if (mdu != mdd) begin
            m_up = mdu; m_duty = fs; m_t = 0; mm = M_ACT;
            try_fire();
          end
        end
        M_ACT: begin
          if (m_t != 0 && (!(m_up ? mdu : mdd) || (m_up ? mdd : mdu)))
            mm = M_WAIT;
          else begin
            m_t++;
            if (m_t == RD || (m_t > RD && (m_t - RD) % RP == 0)) try_fire();
          end
        end
        default: if (!mdu && !mdd) mm = M_IDLE;
      endcase
      if (su2 != mdu) begin
        ru++;
        if (ru == D) begin mdu = su2; ru = 0; end
      end else ru = 0;
      if (sd2 != mdd) begin
        rdn++;
        if (rdn == D) begin mdd = sd2; rdn = 0; end
      end else rdn = 0;
      su2 = su1; su1 = btn_up;
      sd2 = sd1; sd1 = btn_down;
    end
  end

  // Monitor
  always @(negedge clk) begin
    int nh, kind, idx, exp_al;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      check("missing_pulse", -1, q[0].kind);
      void'(q.pop_front());
    end
    nh = int'(inc_frec) + int'(dec_frec) + int'(inc_duty) + int'(dec_duty);
    if (nh > 0) begin
      pc++;
      check("one_hot", nh, 1);
      kind = inc_frec ? 0 : dec_frec ? 1 : inc_duty ? 2 : 3;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        check("pulse_kind", kind, q[0].kind);
        void'(q.pop_front());
      end else begin
        check("unexpected_pulse", kind, -1);
      end
    end
    if (mm != M_WAIT) begin
      idx = m_duty ? int'(duty_idx) : int'(frec_idx);
      exp_al = 0;
      if (mm == M_ACT)
        exp_al = m_up ? int'(mdu && idx == IMAX) : int'(mdd && idx == 0);
      check("at_limit", int'(at_limit), exp_al);
    end
  end

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_idx(int f, int d);
    @(negedge clk);
    ld = 1'b1; ld_f = 4'(f); ld_d = 4'(d);
    @(negedge clk);
    ld = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w, n, pc0;
    cycles(3);
    check("rst_inc_frec", int'(inc_frec), 0);
    check("rst_dec_frec", int'(dec_frec), 0);
    check("rst_inc_duty", int'(inc_duty), 0);
    check("rst_dec_duty", int'(dec_duty), 0);
    check("rst_at_limit", int'(at_limit), 0);
    rst_n = 1'b1;
    cycles(2);

    // glitches then a clean press
    set_idx(5, 9);
    fs = 1'b0;
    pc0 = pc;
    repeat (2) begin
      btn_up = 1'b1; cycles(3);
      btn_up = 1'b0; cycles(3);
    end
    check("glitch_pulses", pc - pc0, 0);
    btn_up = 1'b1; w = 0;
    do begin @(posedge clk); #1; w++; end while (!inc_frec && w < 20);
    check("first_latency", w, 7);
    @(negedge clk); btn_up = 1'b0;
    cycles(15);
    check("s1_pulses", pc - pc0, 1);
    check("s1_frec", int'(frec_idx), 6);

    // long hold with auto-repeat on duty
    set_idx(6, 9);
    fs = 1'b1; pc0 = pc;
    btn_down = 1'b1; cycles(60);
    btn_down = 1'b0; cycles(15);
    check("s2_pulses", pc - pc0, 6);
    check("s2_duty", int'(duty_idx), 3);
    check("s2_duty_model", int'(duty_idx), ed);

    // saturation at the top
    set_idx(14, 3);
    fs = 1'b0; pc0 = pc;
    btn_up = 1'b1; cycles(30);
    check("s3_at_limit", int'(at_limit), 1);
    cycles(20);
    check("s3_frec", int'(frec_idx), 15);
    btn_up = 1'b0; cycles(15);
    check("s3_pulses", pc - pc0, 1);
    check("s3_at_limit_rel", int'(at_limit), 0);

    // both buttons together
    set_idx(3, 3);
    pc0 = pc;
    btn_up = 1'b1; btn_down = 1'b1; cycles(15);
    btn_up = 1'b0; cycles(8);
    check("s4_both_pulses", pc - pc0, 0);
    btn_down = 1'b0; cycles(12);
    btn_up = 1'b1; cycles(10);
    btn_up = 1'b0; cycles(12);
    check("s4_after_pulses", pc - pc0, 1);
    check("s4_frec", int'(frec_idx), 4);

    // target select toggles mid-hold
    set_idx(2, 2);
    fs = 1'b0; pc0 = pc;
    btn_up = 1'b1; cycles(10);
    fs = 1'b1; cycles(30);
    btn_up = 1'b0; cycles(15);
    check("s5_pulses", pc - pc0, 4);
    check("s5_frec", int'(frec_idx), 6);
    check("s5_duty", int'(duty_idx), 2);
    btn_up = 1'b1; cycles(8);
    btn_up = 1'b0; cycles(15);
    check("s5_next_duty", int'(duty_idx), 3);
    check("s5_next_frec", int'(frec_idx), 6);

    // reset during repeat
    set_idx(10, 3);
    fs = 1'b0;
    btn_down = 1'b1; n = 0; w = 0;
    while (n < 3 && w < 200) begin
      @(posedge clk); #1; w++;
      if (dec_frec) n++;
    end
    check("s6_repeat_reached", n, 3);
    rst_n = 1'b0;
    #1;
    check("s6_rst_inc_frec", int'(inc_frec), 0);
    check("s6_rst_dec_frec", int'(dec_frec), 0);
    check("s6_rst_inc_duty", int'(inc_duty), 0);
    check("s6_rst_dec_duty", int'(dec_duty), 0);
    check("s6_rst_at_limit", int'(at_limit), 0);
    cycles(3);
    rst_n = 1'b1; w = 0;
    do begin @(posedge clk); #1; w++; end while (!dec_frec && w < 30);
    check("s6_relatch_latency", w, 7);
    @(negedge clk); btn_down = 1'b0;
    cycles(15);
    check("s6_frec_model", int'(frec_idx), ef);
    check("s6_frec", int'(frec_idx), 7);

    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_ajuste_conmutacion.md
# control_ajuste_conmutacion

Front-end controller for the switching-frequency adjust path: synchronizes and debounces the raw up/down push-buttons, routes each accepted press to either the frequency index or the duty index according to `funct_select`, and issues saturating single-cycle step pulses with press-and-hold auto-repeat. It sits between the board buttons and the up/down register/counter that drives the divider (MDF). It replaces direct button wiring so that each counter sees exactly one clean enable per intended step.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive stable cycles (10 ms at 100 MHz) before a level change is accepted
- `REPEAT_DELAY`, 50_000_000, hold time after the first step before auto-repeat starts (0.5 s)
- `REPEAT_PERIOD`, 20_000_000, cycles between auto-repeat steps (0.2 s)
- `IDX_MAX`, 15, upper saturation value of both 4-bit indices
- `CLK_100MHz` input 1: system clock; one clock domain only
- `reset` input 1: asynchronous, active-low reset
- `btn_up` input 1: raw increase button, asynchronous, active-high
- `btn_down` input 1: raw decrease button, asynchronous, active-high
- `funct_select` input 1: 0 = frequency target, 1 = duty target
- `frec_idx` input 4: current frequency counter value, used for saturation
- `duty_idx` input 4: current duty counter value, used for saturation
- `inc_frec`, `dec_frec` output 1 each: one-cycle step pulses to the frequency counter
- `inc_duty`, `dec_duty` output 1 each: one-cycle step pulses to the duty counter
- `at_limit` output 1: high while the latched target index is at 0 (down held) or `IDX_MAX` (up held)

## Operation
- Buttons pass a 2-flop synchronizer, then a per-button debouncer. The debounced level changes only after `DEBOUNCE_CYCLES` consecutive equal synchronized samples. Any disagreement restarts the count.
- FSM states:
  - IDLE -> PRESS when exactly one debounced button is high. Latch direction and `funct_select` into `tgt`.
  - PRESS: emit one step pulse, -> HOLD.
  - HOLD: count `REPEAT_DELAY`, -> REPEAT on expiry.
  - REPEAT: emit one step every `REPEAT_PERIOD` cycles.
  - HOLD/REPEAT -> WAIT_REL when the held button drops or the other button rises.
  - WAIT_REL -> IDLE when both debounced buttons are low.
- Both buttons high from IDLE: go directly to WAIT_REL. No pulse is emitted.
- Saturation: an up pulse is suppressed when the target index equals `IDX_MAX`, and a down pulse is suppressed at 0. The FSM still advances normally.
- `funct_select` changes while a button is held have no effect on the current press; the latched `tgt` applies until IDLE.
- At most one of the four pulse outputs is high in any cycle.

## Timing
- Reset (asynchronous assert, synchronous-to-clock release): state IDLE, all counters 0, all pulse outputs 0, `at_limit` 0, debounced levels 0.
- Raw edge to first pulse: 2 (sync) + `DEBOUNCE_CYCLES` + 1 (IDLE->PRESS) cycles. The pulse is registered and appears the cycle after PRESS is entered.
- Second pulse: `REPEAT_DELAY` cycles after the first. Subsequent pulses follow every `REPEAT_PERIOD` cycles exactly.
- Index inputs are sampled in the cycle the pulse is generated. The counter updates one cycle later, so a pulse is never issued on consecutive cycles (`REPEAT_PERIOD` >= 2 is required).
- Reset asserted mid-repeat: pulses stop in the same cycle (asynchronous clear). After release, a still-held button is re-debounced from scratch.
- `at_limit` is combinational from the latched `tgt` and the index inputs, and is gated to 0 in IDLE.

## Structure
- Shared package `ajuste_pkg`:
  - FSM state enum (IDLE, PRESS, HOLD, REPEAT, WAIT_REL)
  - target encoding (`TGT_FREC` = 0, `TGT_DUTY` = 1)
  - direction encoding
  - default timing constants
- One sub-module `sincronizador_antirrebote`: 2-flop synchronizer plus debounce counter, parameterized by `DEBOUNCE_CYCLES`, instantiated once per button. The FSM, repeat counter and pulse routing live in the top module.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8, with a behavioral 4-bit counter model fed by the pulses.
- `btn_up` bounces 3-cycle glitches, then is held 7 cycles, `funct_select`=0, `frec_idx`=5 -> no pulse from the glitches; exactly one `inc_frec` arrives 7 cycles after the stable edge; `frec_idx` becomes 6.
- `btn_down` held 60 cycles, `funct_select`=1, `duty_idx`=9 -> `dec_duty` pulses at t0, t0+20, t0+28, t0+36, t0+44, t0+52; `duty_idx` ends at 3.
- `btn_up` held with `frec_idx`=14 -> one pulse to 15, then no further pulses; `at_limit`=1 until release.
- Both buttons pressed in the same cycle -> zero pulses; FSM holds in WAIT_REL until both are released, then accepts a new up press normally.
- `funct_select` toggles 0->1 during a hold -> all pulses remain `inc_frec`; the next press goes to `inc_duty`.
- `reset` low during REPEAT -> pulses drop within the same cycle and all outputs read 0; after release with the button still held, the first pulse arrives after 2 + 4 + 1 cycles.
